and_nand_nor_32: RTL and testbench

Registered 32-bit bitwise logic unit that computes AND, NAND or NOR of two operands. It serves as the AND/NAND/NOR functional unit behind the ALU's opcode decoder. Operands are sampled on a clock edge, and the result is presented one cycle later on a 32-bit output. That output can optionally share the ALU result bus.

---
 rtl/alu_logic_pkg.sv | 17 +
 rtl/bitwise_core.sv | 31 +++
 rtl/and_nand_nor_32.sv | 71 +++++++
 tb/tb_and_nand_nor_32.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU bitwise-logic functional units.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: alu_op_e operation select encoding, ALU_WIDTH default datapath width.
package alu_logic_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        LOGIC_AND  = 2'd0,
        LOGIC_NAND = 2'd1,
        LOGIC_NOR  = 2'd2,
        LOGIC_RSVD = 2'd3
    } alu_op_e;

endpackage : alu_logic_pkg

// File: rtl/bitwise_core.sv
// Combinational per-bit AND / NAND / NOR; reserved op yields all zeros.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   op : operation select (alu_op_e)
//   a  : operand A, WIDTH bits
//   b  : operand B, WIDTH bits
//   y  : result, WIDTH bits; bit i depends on a[i], b[i] only
module bitwise_core
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            LOGIC_AND:  y = a & b;
            LOGIC_NAND: y = ~(a & b);
            LOGIC_NOR:  y = ~(a | b);
            default:    y = '0;   // LOGIC_RSVD: zero result, still reported valid
        endcase
    end

endmodule : bitwise_core

// File: rtl/and_nand_nor_32.sv
// Registered AND/NAND/NOR functional unit behind the ALU opcode decoder.
// Latency: 1 cycle from the sampling edge (en high) to out/out_valid.
// Backpressure: none; accepts one request per cycle, out_valid pulses per result.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears out and out_valid)
//   en            : request; op/a/b sampled on the same rising edge
//   op            : 2-bit operation select (alu_op_e encoding)
//   a, b          : WIDTH-bit operands
//   out           : registered result
//   out_valid     : high for the cycle in which out carries a fresh result
// Build option: AND_NAND_NOR_TRISTATE_OUT_EN -- when defined, out is driven only
// while out_valid is high and is high-impedance otherwise (shared result bus).
module and_nand_nor_32
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] out_d, out_q;
    logic             vld_d, vld_q;

    bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (alu_op_e'(op)),
        .a  (a),
        .b  (b),
        .y  (core_y)
    );

    // The core output is only consumed when en is high, so X/Z on the
    // operands during idle cycles never reaches the result register.
    always_comb begin
        out_d = out_q;
        vld_d = 1'b0;
        if (en) begin
            out_d = core_y;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q;

`ifdef AND_NAND_NOR_TRISTATE_OUT_EN
    assign out = vld_q ? out_q : {WIDTH{1'bz}};
`else
    assign out = out_q;
`endif

endmodule : and_nand_nor_32

// File: tb/tb_and_nand_nor_32.sv
// Self-checking bench for and_nand_nor_32 using a queue-based scoreboard.
// Latency: checks exactly 1-cycle request-to-result timing.
// Backpressure: n/a (unit has none).
module tb_and_nand_nor_32;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         out_valid;

    logic [W-1:0] sb[$];
    logic [W-1:0] last_res;
    logic [W-1:0] exp_v;
    int           n_checks;
    int           n_pass;

    and_nand_nor_32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] m_op,
                                           input logic [W-1:0] m_a,
                                           input logic [W-1:0] m_b);
        case (m_op)
            2'd0:    return m_a & m_b;
            2'd1:    return ~(m_a & m_b);
            2'd2:    return ~(m_a | m_b);
            default: return '0;
        endcase
    endfunction

    // Apply inputs just after an edge, then advance to 1 time unit past the
    // next rising edge, where the registered outputs are stable.
    task automatic cycle(input logic c_rst, input logic c_en, input logic [1:0] c_op,
                         input logic [W-1:0] c_a, input logic [W-1:0] c_b);
        rst = c_rst;
        en  = c_en;
        op  = c_op;
        a   = c_a;
        b   = c_b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL reset_valid[%0d]: got %b want 0", i, out_valid);
            else n_pass++;
            n_checks++;
`ifdef AND_NAND_NOR_TRISTATE_OUT_EN
            if (out !== {W{1'bz}})
                $display("FAIL reset_out[%0d]: got %h want zzzzzzzz", i, out);
            else n_pass++;
`else
            if (out !== 32'h0000_0000)
                $display("FAIL reset_out[%0d]: got %h want 00000000", i, out);
            else n_pass++;
`endif
        end
        last_res = 32'h0;
    endtask

    task automatic test_basic();
        logic [1:0]   ops [3];
        logic [W-1:0] exps[3];
        ops  = '{2'd0, 2'd1, 2'd2};
        exps = '{32'hF000_F000, 32'h0FFF_0FFF, 32'h000F_000F};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exps[i]);
            cycle(1'b0, 1'b1, ops[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
            n_checks++;
            if (out_valid !== 1'b1)
                $display("FAIL basic_valid[%0d]: got %b want 1", i, out_valid);
            else n_pass++;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                n_checks++;
                if (out !== exp_v)
                    $display("FAIL basic_out[%0d]: got %h want %h", i, out, exp_v);
                else n_pass++;
                last_res = exp_v;
            end
            // Idle cycle: valid must drop, proving the result came after exactly one edge.
            cycle(1'b0, 1'b0, ops[i], 32'h0, 32'h0);
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL basic_idle_valid[%0d]: got %b want 0", i, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ops[3];
        logic [W-1:0] as [3];
        logic [W-1:0] exps[3];
        ops  = '{2'd0, 2'd1, 2'd2};
        as   = '{32'hA5A5_A5A5, 32'h0, 32'h0};
        exps = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exps[i]);
            cycle(1'b0, 1'b1, ops[i], as[i], (i == 0) ? 32'hFFFF_FFFF : 32'h0);
            n_checks++;
            if (out_valid !== 1'b1)
                $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid);
            else n_pass++;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                n_checks++;
                if (out !== exp_v)
                    $display("FAIL b2b_out[%0d]: got %h want %h", i, out, exp_v);
                else n_pass++;
                last_res = exp_v;
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cycle(1'b0, 1'b0, 2'd3, 'x, 'z);
            else        cycle(1'b0, 1'b0, 2'(i), $urandom, $urandom);
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid);
            else n_pass++;
            n_checks++;
`ifdef AND_NAND_NOR_TRISTATE_OUT_EN
            if (out !== {W{1'bz}})
                $display("FAIL hold_out[%0d]: got %h want zzzzzzzz", i, out);
            else n_pass++;
`else
            if (out !== last_res)
                $display("FAIL hold_out[%0d]: got %h want %h", i, out, last_res);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reserved();
        sb.push_back(32'h0000_0000);
        cycle(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (out_valid !== 1'b1)
            $display("FAIL rsvd_valid: got %b want 1", out_valid);
        else n_pass++;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_checks++;
            if (out !== exp_v)
                $display("FAIL rsvd_out: got %h want %h", out, exp_v);
            else n_pass++;
            last_res = exp_v;
        end
    endtask

    task automatic test_reset_priority();
        // A request accepted one edge before reset must not survive it either.
        cycle(1'b0, 1'b1, 2'd1, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rstpri_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out === 32'hFFFF_FFFF)
            $display("FAIL rstpri_out: got %h want not ffffffff", out);
        else n_pass++;
        n_checks++;
`ifdef AND_NAND_NOR_TRISTATE_OUT_EN
        if (out !== {W{1'bz}})
            $display("FAIL rstpri_clear: got %h want zzzzzzzz", out);
        else n_pass++;
`else
        if (out !== 32'h0)
            $display("FAIL rstpri_clear: got %h want 00000000", out);
        else n_pass++;
`endif
        last_res = 32'h0;
    endtask

    task automatic test_random();
        logic         r_en;
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        for (int i = 0; i < 40; i++) begin
            r_en = 1'($urandom_range(0, 3) != 0);
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if (r_en) sb.push_back(model(r_op, r_a, r_b));
            cycle(1'b0, r_en, r_op, r_a, r_b);
            n_checks++;
            if (out_valid !== r_en)
                $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, r_en);
            else n_pass++;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_spurious[%0d]: got result %h want none", i, out);
                end else begin
                    exp_v = sb.pop_front();
                    if (out !== exp_v)
                        $display("FAIL rand_out[%0d]: got %h want %h", i, out, exp_v);
                    else n_pass++;
                end
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        last_res = '0;
        rst = 1'b1;
        en  = 1'b0;
        op  = 2'd0;
        a   = '0;
        b   = '0;
        #2;
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_reserved();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_and_nand_nor_32
